// File: rtl/serial_word_tx_pkg.sv
// serial_word_tx_pkg: shared types and widths for the serial word transmitter.
//   state_e    : frame sequencer states
//   GAP_CNT_W  : inter-frame gap counter width (GAP_CYCLES up to 15)
//   bit_cnt_w(): bit counter width for a given word width
package serial_word_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_e;

    localparam int unsigned GAP_CNT_W = 4;

    // Bit counter spans 0..width-1; words are at least 2 bits wide.
    function automatic int unsigned bit_cnt_w(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_word_tx_shreg.sv
// serial_word_tx_shreg: WIDTH-bit load/shift register feeding the serial line.
//   clk, rst_n : clock, async active-low clear
//   load       : capture d (head bit already consumed, see below)
//   shift      : advance one bit toward the serial end
//   lsb_first  : 1 shifts right (LSB leaves first), 0 shifts left
//   d          : parallel word
//   sout       : bit that goes on the line at the next shift
module serial_word_tx_shreg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic             lsb_first,
    input  logic [WIDTH-1:0] d,
    output logic             sout
);

    logic [WIDTH-1:0] q;

    // The first bit is launched straight from d on the load edge, so the
    // register stores the word already advanced by one position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= lsb_first ? (d >> 1) : (d << 1);
        end else if (shift) begin
            q <= lsb_first ? (q >> 1) : (q << 1);
        end
    end

    assign sout = lsb_first ? q[0] : q[WIDTH-1];

endmodule

// File: rtl/serial_word_tx.sv
// serial_word_tx: valid/ready parallel-to-serial framer, one word per frame.
//   CLK, RN  : clock (rising edge), async active-low reset
//   D        : parallel word, sampled on the accepting edge
//   D_VALID  : producer offers D
//   D_READY  : combinational from registered state; word accepted this edge
//   SO       : serial data, idles at 1
//   SO_EN    : SO carries a data bit
//   SO_LAST  : final bit of the frame
//   BUSY     : frame or inter-frame gap in progress
module serial_word_tx
    import serial_word_tx_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned LSB_FIRST  = 0,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic [WIDTH-1:0] D,
    input  logic             D_VALID,
    output logic             D_READY,
    output logic             SO,
    output logic             SO_EN,
    output logic             SO_LAST,
    output logic             BUSY
);

    localparam int unsigned BIT_CNT_W = bit_cnt_w(WIDTH);
    localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(WIDTH - 1);
    localparam logic [GAP_CNT_W-1:0] GAP_LAST =
        GAP_CNT_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
    localparam bit HAS_GAP = (GAP_CYCLES != 0);

    state_e                 state_q, state_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [GAP_CNT_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic                   accept;
    logic                   shift;
    logic                   sout;
    logic                   d_head;
    logic                   so_d, so_en_d, so_last_d, busy_d;

    assign accept = D_VALID & D_READY;
    assign d_head = (LSB_FIRST != 0) ? D[0] : D[WIDTH-1];

    serial_word_tx_shreg #(
        .WIDTH (WIDTH)
    ) u_shreg (
        .clk       (CLK),
        .rst_n     (RN),
        .load      (accept),
        .shift     (shift),
        .lsb_first (LSB_FIRST != 0),
        .d         (D),
        .sout      (sout)
    );

    // Ready in IDLE and in the final cycle of a frame (last bit or last gap cycle).
    always_comb begin
        D_READY = 1'b0;
        case (state_q)
            IDLE:    D_READY = 1'b1;
            SHIFT:   D_READY = !HAS_GAP && (bit_cnt_q == BIT_LAST);
            GAP:     D_READY = (gap_cnt_q == GAP_LAST);
            default: D_READY = 1'b0;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    // Next-state logic; an accept always wins since it only occurs at frame exits.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        shift     = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            SHIFT: begin
                if (bit_cnt_q != BIT_LAST) begin
                    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    shift     = 1'b1;
                end else if (HAS_GAP) begin
                    state_d   = GAP;
                    gap_cnt_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            GAP: begin
                if (gap_cnt_q != GAP_LAST) begin
                    gap_cnt_d = gap_cnt_q + GAP_CNT_W'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (accept) begin
            state_d   = SHIFT;
            bit_cnt_d = '0;
        end
    end

    // Output decode from the upcoming state; the first bit comes straight from D.
    always_comb begin
        so_d      = 1'b1;
        so_en_d   = 1'b0;
        so_last_d = 1'b0;
        busy_d    = (state_d != IDLE);
        if (state_d == SHIFT) begin
            so_en_d   = 1'b1;
            so_last_d = (bit_cnt_d == BIT_LAST);
            so_d      = accept ? d_head : sout;
        end
    end

    // Registered line outputs.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            SO      <= 1'b1;
            SO_EN   <= 1'b0;
            SO_LAST <= 1'b0;
            BUSY    <= 1'b0;
        end else begin
            SO      <= so_d;
            SO_EN   <= so_en_d;
            SO_LAST <= so_last_d;
            BUSY    <= busy_d;
        end
    end

endmodule

// File: tb/tb_serial_word_tx.sv
// tb_serial_word_tx: three transmitter configurations driven by shared
// stimulus, checked against a frame-timing reference model, directed tables
// and hand-written corner-case sequences.
module tb_serial_word_tx;

    localparam int W = 8;
    localparam int N = 3;

    typedef struct {
        int           dut;
        bit           v;
        logic [W-1:0] d;
        bit           so, en, last, rdy, busy;
    } vec_t;

    logic         clk = 1'b0;
    logic         rn;
    logic         d_valid;
    logic [W-1:0] d;
    logic         rdy_w [N];
    logic         so_w [N];
    logic         en_w [N];
    logic         last_w [N];
    logic         busy_w [N];
    bit           clk_run = 1'b0;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    // Reference model: a frame accepted at edge 'start' occupies the W cycles
    // after it with data, then gap_of() cycles of gap.
    bit           has_f [N];
    int           start [N];
    logic [W-1:0] word  [N];

    vec_t tbl [$];

    serial_word_tx #(.WIDTH(W), .LSB_FIRST(0), .GAP_CYCLES(1)) dut_a (
        .CLK(clk), .RN(rn), .D(d), .D_VALID(d_valid), .D_READY(rdy_w[0]),
        .SO(so_w[0]), .SO_EN(en_w[0]), .SO_LAST(last_w[0]), .BUSY(busy_w[0]));
    serial_word_tx #(.WIDTH(W), .LSB_FIRST(1), .GAP_CYCLES(2)) dut_b (
        .CLK(clk), .RN(rn), .D(d), .D_VALID(d_valid), .D_READY(rdy_w[1]),
        .SO(so_w[1]), .SO_EN(en_w[1]), .SO_LAST(last_w[1]), .BUSY(busy_w[1]));
    serial_word_tx #(.WIDTH(W), .LSB_FIRST(0), .GAP_CYCLES(0)) dut_c (
        .CLK(clk), .RN(rn), .D(d), .D_VALID(d_valid), .D_READY(rdy_w[2]),
        .SO(so_w[2]), .SO_EN(en_w[2]), .SO_LAST(last_w[2]), .BUSY(busy_w[2]));

    always #5 if (clk_run) clk = ~clk;

    function automatic int gap_of(input int i);
        case (i)
            0:       return 1;
            1:       return 2;
            default: return 0;
        endcase
    endfunction

    function automatic bit lsb_of(input int i);
        return (i == 1);
    endfunction

    function automatic bit model_ready(input int i);
        return !has_f[i] || ((cyc - start[i]) >= (W + gap_of(i) - 1));
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %b, want %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got 'h%0h, want 'h%0h", name, act, exp);
        end
    endtask

    task automatic check_model();
        for (int i = 0; i < N; i++) begin
            int   rel    = cyc - start[i];
            logic e_so   = 1'b1;
            logic e_en   = 1'b0;
            logic e_last = 1'b0;
            logic e_busy = 1'b0;
            if (has_f[i] && rel < W) begin
                e_en   = 1'b1;
                e_busy = 1'b1;
                e_last = (rel == W - 1);
                e_so   = lsb_of(i) ? word[i][rel] : word[i][W-1-rel];
            end else if (has_f[i] && rel < W + gap_of(i)) begin
                e_busy = 1'b1;
            end
            chk($sformatf("so[%0d]", i),   so_w[i],   e_so);
            chk($sformatf("so_en[%0d]", i), en_w[i],  e_en);
            chk($sformatf("so_last[%0d]", i), last_w[i], e_last);
            chk($sformatf("busy[%0d]", i), busy_w[i], e_busy);
        end
    endtask

    task automatic check_reset_values(input string tag);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s so[%0d]", tag, i),      so_w[i],   1'b1);
            chk($sformatf("%s so_en[%0d]", tag, i),   en_w[i],   1'b0);
            chk($sformatf("%s so_last[%0d]", tag, i), last_w[i], 1'b0);
            chk($sformatf("%s busy[%0d]", tag, i),    busy_w[i], 1'b0);
            chk($sformatf("%s d_ready[%0d]", tag, i), rdy_w[i],  1'b1);
        end
    endtask

    // One clock: check ready before the edge, update the model, check outputs after.
    task automatic step();
        bit           acc [N];
        logic [W-1:0] d_cap;
        d_cap = d;
        for (int i = 0; i < N; i++) begin
            bit r;
            r = model_ready(i);
            chk($sformatf("d_ready[%0d]", i), rdy_w[i], r);
            acc[i] = r && (d_valid === 1'b1);
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                has_f[i] = 1'b1;
                start[i] = cyc;
                word[i]  = d_cap;
            end
        end
        check_model();
    endtask

    task automatic idle(input int n);
        d_valid = 1'b0;
        repeat (n) step();
    endtask

    function automatic void add(input int dut, input bit v, input logic [W-1:0] dd,
                                input bit so, input bit en, input bit last,
                                input bit rdy, input bit busy);
        vec_t r;
        r.dut = dut; r.v = v; r.d = dd;
        r.so = so; r.en = en; r.last = last; r.rdy = rdy; r.busy = busy;
        tbl.push_back(r);
    endfunction

    initial begin
        int           en_cnt, last_cnt, run, max_run;
        logic [15:0]  rx16;
        logic [W-1:0] rx8;

        // MSB-first 8'hA5 on dut_a (one gap cycle).
        add(0, 1, 8'hA5, 1, 1, 0, 0, 1);
        add(0, 0, 8'h00, 0, 1, 0, 0, 1);
        add(0, 0, 8'h00, 1, 1, 0, 0, 1);
        add(0, 0, 8'h00, 0, 1, 0, 0, 1);
        add(0, 0, 8'h00, 0, 1, 0, 0, 1);
        add(0, 0, 8'h00, 1, 1, 0, 0, 1);
        add(0, 0, 8'h00, 0, 1, 0, 0, 1);
        add(0, 0, 8'h00, 1, 1, 1, 0, 1);
        add(0, 0, 8'h00, 1, 0, 0, 1, 1);
        add(0, 0, 8'h00, 1, 0, 0, 1, 0);
        // LSB-first 8'h01 on dut_b (two gap cycles).
        add(1, 1, 8'h01, 1, 1, 0, 0, 1);
        for (int k = 0; k < 6; k++) add(1, 0, 8'h00, 0, 1, 0, 0, 1);
        add(1, 0, 8'h00, 0, 1, 1, 0, 1);
        add(1, 0, 8'h00, 1, 0, 0, 0, 1);
        add(1, 0, 8'h00, 1, 0, 0, 1, 1);
        add(1, 0, 8'h00, 1, 0, 0, 1, 0);

        for (int i = 0; i < N; i++) begin
            has_f[i] = 1'b0;
            start[i] = 0;
            word[i]  = '0;
        end

        // Reset with the clock stopped.
        rn      = 1'b1;
        d_valid = 1'b0;
        d       = '0;
        #2 rn = 1'b0;
        #1 check_reset_values("reset");

        #5 clk_run = 1'b1;
        @(negedge clk);
        rn = 1'b1;
        idle(2);

        // Directed tables.
        foreach (tbl[k]) begin
            if (tbl[k].v) idle(4);
            d_valid = tbl[k].v;
            d       = tbl[k].d;
            step();
            chk($sformatf("tbl%0d so", k),      so_w[tbl[k].dut],   tbl[k].so);
            chk($sformatf("tbl%0d so_en", k),   en_w[tbl[k].dut],   tbl[k].en);
            chk($sformatf("tbl%0d so_last", k), last_w[tbl[k].dut], tbl[k].last);
            chk($sformatf("tbl%0d d_ready", k), rdy_w[tbl[k].dut],  tbl[k].rdy);
            chk($sformatf("tbl%0d busy", k),    busy_w[tbl[k].dut], tbl[k].busy);
        end

        // Back-to-back FF then 00 on the no-gap configuration.
        idle(4);
        en_cnt = 0; last_cnt = 0; run = 0; max_run = 0; rx16 = '0;
        d_valid = 1'b1;
        d       = 8'hFF;
        for (int k = 0; k < 20; k++) begin
            step();
            if (k == 0) d = 8'h00;
            if (k == 8) d_valid = 1'b0;
            if (en_w[2] === 1'b1) begin
                en_cnt++;
                run++;
                rx16 = {rx16[14:0], so_w[2]};
            end else begin
                run = 0;
            end
            if (run > max_run) max_run = run;
            if (last_w[2] === 1'b1) last_cnt++;
        end
        chk_int("b2b so_en count", en_cnt, 16);
        chk_int("b2b so_en run", max_run, 16);
        chk_int("b2b so_last count", last_cnt, 2);
        chk_int("b2b data", int'(rx16), 'hFF00);

        // Back-pressure: D changes every cycle while not ready.
        idle(4);
        en_cnt = 0; rx16 = '0;
        d_valid = 1'b1;
        d       = 8'h5A;
        step();
        if (en_w[0] === 1'b1) begin en_cnt++; rx16 = {rx16[14:0], so_w[0]}; end
        for (int m = 0; m < 25; m++) begin
            d_valid = (m <= 8);
            d       = (m <= 8) ? (8'h80 | W'(m)) : W'($urandom);
            step();
            if (en_w[0] === 1'b1) begin en_cnt++; rx16 = {rx16[14:0], so_w[0]}; end
        end
        chk_int("bp so_en count", en_cnt, 16);
        chk_int("bp data", int'(rx16), 'h5A88);

        // Reset during bit 4 of 8'h3C.
        idle(4);
        d_valid = 1'b1;
        d       = 8'h3C;
        step();
        d_valid = 1'b0;
        d       = '0;
        repeat (4) step();
        chk("mid so_en before reset", en_w[0], 1'b1);
        #2 rn = 1'b0;
        #1 check_reset_values("mid-reset");
        for (int i = 0; i < N; i++) has_f[i] = 1'b0;
        @(negedge clk);
        rn = 1'b1;
        d_valid = 1'b1;
        d       = 8'hC3;
        rx8     = '0;
        step();
        chk("post-reset first so_en", en_w[0], 1'b1);
        d_valid = 1'b0;
        rx8 = {rx8[W-2:0], so_w[0]};
        for (int k = 1; k < W; k++) begin
            step();
            rx8 = {rx8[W-2:0], so_w[0]};
        end
        chk_int("post-reset data", int'(rx8), 'hC3);

        // Randomized traffic against the model.
        idle(2);
        repeat (400) begin
            d_valid = ($urandom_range(0, 3) != 0);
            d       = W'($urandom);
            step();
        end
        idle(12);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/serial_word_tx.md
# serial_word_tx

Parallel-to-serial transmitter that launches one framed word per handshake on a single bit line. It drives the serial data input of our negative-edge-capture receivers, which use an active-low set so they idle at 1: this block launches on the rising CLK edge, and the far end samples on the falling edge. It sits between a word-oriented producer and the serial link, and provides back-pressure through a valid/ready handshake.

## Interface
- WIDTH, 8: bits per word; must be 2 or more.
- LSB_FIRST, 0: 0 sends the MSB first; 1 sends the LSB first.
- GAP_CYCLES, 1: idle cycles between frames; range 0 to 15.
- CLK  in  1  clock; all state changes on the rising edge.
- RN  in  1  reset; asynchronous and active-low.
- D  in  WIDTH  parallel word; sampled only on the accepting edge.
- D_VALID  in  1  producer has a word on D.
- D_READY  out  1  block can accept a word this cycle.
- SO  out  1  serial data; idles at 1.
- SO_EN  out  1  high while SO carries a data bit.
- SO_LAST  out  1  high with the final bit of a frame.
- BUSY  out  1  a frame or gap is in progress.

## Operation
- FSM states: IDLE, SHIFT, GAP.
- Reset values (RN low, applied asynchronously, regardless of CLK):
  - state = IDLE, shift register = 0, counters = 0.
  - SO = 1, SO_EN = 0, SO_LAST = 0, BUSY = 0.
  - D_READY = 1, because D_READY is combinational from state and counters.
- Accept: a rising edge with D_VALID & D_READY loads D into the shift register and enters SHIFT.
  - D may change on any later cycle.
  - D_VALID without D_READY is ignored, and nothing is latched.
- SHIFT:
  - SO presents bit WIDTH-1 down to bit 0 (or 0 up to WIDTH-1 when LSB_FIRST=1), one bit per cycle.
  - SO_EN = 1 for exactly WIDTH cycles.
  - SO_LAST = 1 on the final bit only.
  - The bit counter runs from 0 to WIDTH-1 and is $clog2(WIDTH) bits wide. It never wraps mid-frame; it is cleared on load.
- GAP: GAP_CYCLES cycles with SO = 1 and SO_EN = 0, then return to IDLE.
  - With GAP_CYCLES = 0, the GAP state is never entered.
- D_READY is high:
  - in IDLE;
  - in the final cycle of a frame: the last bit when GAP_CYCLES = 0, otherwise the last gap cycle.
- Accepting on that final-cycle edge starts the next frame with no idle cycle.
- Sustained throughput is one word per WIDTH + GAP_CYCLES cycles.
- BUSY = 1 in SHIFT and GAP.
- Reset mid-frame: the outputs return to their reset values immediately and the frame in flight is discarded. After RN rises, the first rising edge can accept.

## Timing
- Latency: word accepted at edge k gives its first bit on SO after edge k and valid through edge k+1. Its last bit is valid between edges k+WIDTH-1 and k+WIDTH.
- SO, SO_EN, SO_LAST and BUSY are registered outputs and change only after a rising edge or on RN assertion.
- D_READY is combinational from registered state only. There is no D_VALID-to-D_READY path.
- The receiver samples on the falling edge. This gives a half-cycle setup budget: clock-to-Q plus wire delay must be less than T/2 minus receiver setup.
- RN deassertion is synchronous to CLK by system contract; no internal synchronizer is provided.

## Structure
- Package serial_word_tx_pkg holds:
  - the state enum (IDLE, SHIFT, GAP);
  - the counter-width localparams: bit counter $clog2(WIDTH), gap counter 4 bits.
- One sub-module, serial_word_tx_shreg: a WIDTH-bit load/shift register.
  - Ports: load, shift, direction (from LSB_FIRST), serial out.
  - Active-low async clear.
- The top level holds the FSM, the bit and gap counters, and the output registers.

## Test plan
- Reset: RN low with CLK stopped. SO=1, SO_EN=0, SO_LAST=0, BUSY=0 and D_READY=1 must hold immediately, without any clock edge.
- Single word: WIDTH=8, LSB_FIRST=0, D=8'hA5 accepted at edge 0. SO = 1,0,1,0,0,1,0,1 over cycles 1–8; SO_LAST in cycle 8 only; one gap cycle with SO=1; D_READY high in the gap cycle.
- LSB first: LSB_FIRST=1, D=8'h01. SO = 1 then seven 0s.
- Back-to-back: GAP_CYCLES=0 with D_VALID held high for 8'hFF then 8'h00. Sixteen contiguous SO_EN cycles, two SO_LAST pulses, and no idle cycle between frames.
- Back-pressure: D_VALID high mid-frame while D_READY=0, with D changing every cycle. Only the value present at the next ready edge is transmitted.
- Reset mid-frame: RN pulsed low during bit 4 of 8'h3C. SO goes to 1 and SO_EN to 0 immediately. After release, a new word 8'hC3 transmits correctly starting one cycle after acceptance.
